// File: rtl/retospect_bs_loader.sv
// Configuration-chain loader: serializes host bytes LSB first into the neurochip chain
// and packs the bits falling out of the chain end into readback bytes.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_BYTE | byte_ready high, chain held (config_en low)
//   SHIFT     | one chain bit per clock, readback sampled on the same edge
//   NN_PULSE  | one-cycle reset_nn to the chain
//   FINISH    | done pulse, busy already low
module retospect_bs_loader #(
    parameter int CHAIN_LEN = 1093,
    parameter int CNT_W     = 11,
    parameter int NN_AFTER  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       chain_config_en,
    output logic       chain_bs_out,
    input  logic       chain_bs_in,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       chain_reset_nn,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, NN_PULSE, FINISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [6:0]       shreg;
    logic [3:0]       bits_left;
    logic [7:0]       rb_acc;
    logic [CNT_W-1:0] remain;
    logic [3:0]       nb;
    logic [7:0]       rb_next;

    // Readback bit position equals the chain bit index modulo 8.
    always_comb begin
        remain  = LEN - count;
        nb      = (remain >= CNT_W'(8)) ? 4'd8 : remain[3:0];
        rb_next = rb_acc;
        rb_next[count[2:0]] = chain_bs_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            shreg           <= '0;
            bits_left       <= '0;
            rb_acc          <= '0;
            rb_data         <= '0;
            rb_valid        <= 1'b0;
            byte_ready      <= 1'b0;
            chain_config_en <= 1'b0;
            chain_bs_out    <= 1'b0;
            chain_reset_nn  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT_BYTE;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        count      <= '0;
                        rb_acc     <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid) begin
                        shreg           <= byte_data[7:1];
                        chain_bs_out    <= byte_data[0];
                        chain_config_en <= 1'b1;
                        byte_ready      <= 1'b0;
                        bits_left       <= nb;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg        <= {1'b0, shreg[6:1]};
                    chain_bs_out <= shreg[0];
                    count        <= count + CNT_W'(1);
                    bits_left    <= bits_left - 4'd1;
                    if (count[2:0] == 3'd7 || count == LAST) begin
                        rb_data  <= rb_next;
                        rb_valid <= 1'b1;
                        rb_acc   <= '0;
                    end else begin
                        rb_acc <= rb_next;
                    end
                    if (bits_left == 4'd1) begin
                        chain_config_en <= 1'b0;
                        chain_bs_out    <= 1'b0;
                        if (count == LAST) begin
                            if (NN_AFTER != 0) begin
                                chain_reset_nn <= 1'b1;
                                state          <= NN_PULSE;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= FINISH;
                            end
                        end else begin
                            byte_ready <= 1'b1;
                            state      <= WAIT_BYTE;
                        end
                    end
                end
                NN_PULSE: begin
                    chain_reset_nn <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Bench for retospect_bs_loader: a full-length instance and a 12-bit instance, each
// attached to a behavioural chain; readback bytes are scoreboarded against the chain contents.
module tb_retospect_bs_loader;

    localparam int N  = 1093;
    localparam int NB = 137;
    localparam int SN = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, byte_valid, byte_ready, chain_config_en, chain_bs_out, chain_bs_in;
    logic       rb_valid, chain_reset_nn, busy, done;
    logic [7:0] byte_data, rb_data;
    logic       s_start, s_byte_valid, s_byte_ready, s_config_en, s_bs_out, s_bs_in;
    logic       s_rb_valid, s_reset_nn, s_busy, s_done;
    logic [7:0] s_byte_data, s_rb_data;

    retospect_bs_loader dut (
        .clk(clk), .reset(reset), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .chain_config_en(chain_config_en), .chain_bs_out(chain_bs_out),
        .chain_bs_in(chain_bs_in), .rb_data(rb_data), .rb_valid(rb_valid),
        .chain_reset_nn(chain_reset_nn), .busy(busy), .done(done)
    );

    retospect_bs_loader #(.CHAIN_LEN(SN), .CNT_W(5), .NN_AFTER(0)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .byte_data(s_byte_data), .byte_valid(s_byte_valid),
        .byte_ready(s_byte_ready), .chain_config_en(s_config_en), .chain_bs_out(s_bs_out),
        .chain_bs_in(s_bs_in), .rb_data(s_rb_data), .rb_valid(s_rb_valid),
        .chain_reset_nn(s_reset_nn), .busy(s_busy), .done(s_done)
    );

    // Behavioural chains: shift on config_en, last bit visible at the end.
    logic [N-1:0]  chain   = '0;
    logic [SN-1:0] s_chain = '0;
    always @(posedge clk) if (chain_config_en) chain <= {chain[N-2:0], chain_bs_out};
    always @(posedge clk) if (s_config_en) s_chain <= {s_chain[SN-2:0], s_bs_out};
    assign chain_bs_in = chain[N-1];
    assign s_bs_in     = s_chain[SN-1];

    int n_cmp = 0;
    int n_mis = 0;
    int cfg_cnt = 0, hs_cnt = 0, busy_cnt = 0, nn_cnt = 0, done_cnt = 0, rb_cnt = 0;
    int s_cfg_cnt = 0, s_hs_cnt = 0, s_nn_cnt = 0, s_done_cnt = 0, s_rb_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] s_exp_q[$];
    logic [7:0] pats [4][NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic big_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic small_start();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    // Returns one time unit after the handshake edge, i.e. inside the first shift cycle.
    task automatic big_send(input logic [7:0] b);
        int k = 0;
        byte_data = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && k < 50) begin @(negedge clk); k++; end
        check("ready_timeout", 32'(byte_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic small_send(input logic [7:0] b);
        int k = 0;
        s_byte_data = b;
        s_byte_valid = 1'b1;
        @(negedge clk);
        while (!s_byte_ready && k < 50) begin @(negedge clk); k++; end
        check("s_ready_timeout", 32'(s_byte_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic big_wait_done();
        int k = 0;
        byte_valid = 1'b0;
        do begin @(negedge clk); k++; end while (!done && k < 100);
        check("done_timeout", 32'(done), 1);
        @(negedge clk);
    endtask

    task automatic small_wait_done();
        int k = 0;
        s_byte_valid = 1'b0;
        do begin @(negedge clk); k++; end while (!s_done && k < 100);
        check("s_done_timeout", 32'(s_done), 1);
        @(negedge clk);
    endtask

    initial begin
        int c0, h0, b0, n0, d0, r0, cnt;
        logic prev_nn, s_prev_nn;
        logic [7:0] seq, eb;

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        s_start = 1'b0; s_byte_valid = 1'b0; s_byte_data = '0;
        prev_nn = 1'b0; s_prev_nn = 1'b0;
        for (int i = 0; i < NB; i++) begin
            pats[0][i] = 8'(i);
            pats[1][i] = 8'(i * 37 + 90);
            pats[2][i] = ~8'(i);
            pats[3][i] = 8'(i * 113 + 7);
        end
        pats[1][10] = 8'hA5;

        fork
            forever begin
                @(negedge clk);
                if (chain_config_en) cfg_cnt++;
                if (byte_valid && byte_ready) hs_cnt++;
                if (busy) busy_cnt++;
                if (chain_reset_nn) begin
                    nn_cnt++;
                    check("nn_with_cfg", 32'(chain_config_en), 0);
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy", 32'(busy), 0);
                    check("done_after_nn", 32'(prev_nn), 1);
                end
                prev_nn = chain_reset_nn;
                if (rb_valid) begin
                    rb_cnt++;
                    check("rb_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("rb_data", 32'(rb_data), 32'(exp_q.pop_front()));
                end
                if (s_config_en) s_cfg_cnt++;
                if (s_byte_valid && s_byte_ready) s_hs_cnt++;
                if (s_reset_nn) s_nn_cnt++;
                if (s_done) begin
                    s_done_cnt++;
                    check("s_done_busy", 32'(s_busy), 0);
                end
                if (s_rb_valid) begin
                    s_rb_cnt++;
                    check("s_rb_expected", 32'(s_exp_q.size() > 0), 1);
                    if (s_exp_q.size() > 0) check("s_rb_data", 32'(s_rb_data), 32'(s_exp_q.pop_front()));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({byte_ready, chain_config_en, chain_bs_out, rb_valid,
                                  chain_reset_nn, busy, done, rb_data}), 0);
        check("s_rst_outputs", 32'({s_byte_ready, s_config_en, s_bs_out, s_rb_valid,
                                    s_reset_nn, s_busy, s_done, s_rb_data}), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Load 1: pattern A, byte_valid always high, stray start during a shift.
        c0 = cfg_cnt; h0 = hs_cnt; b0 = busy_cnt; n0 = nn_cnt; d0 = done_cnt; r0 = rb_cnt;
        for (int i = 0; i < NB; i++) exp_q.push_back(8'h00);
        big_start();
        for (int i = 0; i < NB; i++) begin
            big_send(pats[0][i]);
            if (i == 5) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        big_wait_done();
        check("l1_cfg_cycles", cfg_cnt - c0, N);
        check("l1_handshakes", hs_cnt - h0, NB);
        check("l1_busy_cycles", busy_cnt - b0, 1231);
        check("l1_nn_pulses", nn_cnt - n0, 1);
        check("l1_done_pulses", done_cnt - d0, 1);
        check("l1_rb_strobes", rb_cnt - r0, NB);
        check("l1_rb_left", exp_q.size(), 0);

        // Load 2: pattern B with a stall after 0xA5; readback must be pattern A.
        c0 = cfg_cnt; h0 = hs_cnt; n0 = nn_cnt; d0 = done_cnt; r0 = rb_cnt;
        for (int i = 0; i < NB; i++) exp_q.push_back(i == NB - 1 ? (pats[0][i] & 8'h1F) : pats[0][i]);
        big_start();
        for (int i = 0; i < NB; i++) begin
            big_send(pats[1][i]);
            if (i == 10) begin
                byte_valid = 1'b0;
                seq = '0;
                for (int k = 0; k < 8; k++) begin @(negedge clk); seq[k] = chain_bs_out; end
                check("bs_seq_a5", 32'(seq), 32'h0000_00A5);
                cnt = 0;
                repeat (20) begin @(negedge clk); cnt += int'(chain_config_en); end
                check("gap_cfg_en", cnt, 0);
                check("gap_ready", 32'(byte_ready), 1);
                @(posedge clk); #1;
            end
        end
        big_wait_done();
        check("l2_cfg_cycles", cfg_cnt - c0, N);
        check("l2_handshakes", hs_cnt - h0, NB);
        check("l2_nn_pulses", nn_cnt - n0, 1);
        check("l2_done_pulses", done_cnt - d0, 1);
        check("l2_rb_strobes", rb_cnt - r0, NB);
        check("l2_rb_left", exp_q.size(), 0);

        // Load 3: reset during the 4th shift cycle of byte 10.
        r0 = rb_cnt;
        for (int i = 0; i < 10; i++) exp_q.push_back(pats[1][i]);
        big_start();
        for (int i = 0; i < 11; i++) big_send(pats[2][i]);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 32'({byte_ready, chain_config_en, chain_bs_out, rb_valid,
                                     chain_reset_nn, busy, done, rb_data}), 0);
        repeat (5) @(negedge clk);
        check("l3_rb_strobes", rb_cnt - r0, 10);
        check("l3_rb_left", exp_q.size(), 0);

        // Load 4: complete load from a partially shifted chain.
        c0 = cfg_cnt; h0 = hs_cnt; n0 = nn_cnt; d0 = done_cnt; r0 = rb_cnt;
        for (int b = 0; b < NB; b++) begin
            eb = '0;
            for (int t = 0; t < 8; t++) if (b * 8 + t < N) eb[t] = chain[N - 1 - (b * 8 + t)];
            exp_q.push_back(eb);
        end
        big_start();
        for (int i = 0; i < NB; i++) big_send(pats[3][i]);
        big_wait_done();
        check("l4_cfg_cycles", cfg_cnt - c0, N);
        check("l4_handshakes", hs_cnt - h0, NB);
        check("l4_nn_pulses", nn_cnt - n0, 1);
        check("l4_done_pulses", done_cnt - d0, 1);
        check("l4_rb_strobes", rb_cnt - r0, NB);
        check("l4_rb_left", exp_q.size(), 0);

        // byte_valid in IDLE without start is never accepted.
        h0 = hs_cnt; cnt = 0;
        byte_data = 8'h3C; byte_valid = 1'b1;
        repeat (10) begin @(negedge clk); cnt += int'(byte_ready) + int'(busy); end
        byte_valid = 1'b0;
        check("idle_ready_busy", cnt, 0);
        check("idle_handshakes", hs_cnt - h0, 0);

        // 12-bit chain, no reset_nn.
        c0 = s_cfg_cnt; h0 = s_hs_cnt; n0 = s_nn_cnt; d0 = s_done_cnt; r0 = s_rb_cnt;
        s_exp_q.push_back(8'h00); s_exp_q.push_back(8'h00);
        small_start();
        small_send(8'hFF); small_send(8'h03);
        small_wait_done();
        check("s1_cfg_cycles", s_cfg_cnt - c0, SN);
        check("s1_handshakes", s_hs_cnt - h0, 2);
        check("s1_nn_pulses", s_nn_cnt - n0, 0);
        check("s1_done_pulses", s_done_cnt - d0, 1);
        check("s1_rb_strobes", s_rb_cnt - r0, 2);

        c0 = s_cfg_cnt; n0 = s_nn_cnt; d0 = s_done_cnt; r0 = s_rb_cnt;
        s_exp_q.push_back(8'hFF); s_exp_q.push_back(8'h03);
        small_start();
        small_send(8'hA5); small_send(8'hFE);
        small_wait_done();
        check("s2_cfg_cycles", s_cfg_cnt - c0, SN);
        check("s2_nn_pulses", s_nn_cnt - n0, 0);
        check("s2_done_pulses", s_done_cnt - d0, 1);
        check("s2_rb_strobes", s_rb_cnt - r0, 2);
        check("s2_rb_left", s_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
